dot_map: RTL and testbench

DOT_MAP -- requirements
Module: dot_map

---
 rtl/dot_map.sv | 159 +++++++++++++++
 tb/tb_dot_map.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dot_map.sv
// Pac-man maze map, dot bookkeeping and score counter.
// Ports: clk, reset (sync, active-high); query_x/y -> pixel, pixel_R/D/RD, dot;
//        set_x/y (pacman), m_x/y_1..3 (monsters) -> col, gameover, score.
module dot_map #(
    parameter int TILE     = 12,
    parameter int COLS     = 29,
    parameter int ROWS     = 34,
    parameter int COL_DIST = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] query_x,
    input  logic [10:0] query_y,
    output logic [1:0]  pixel,
    output logic [1:0]  pixel_R,
    output logic [1:0]  pixel_D,
    output logic [1:0]  pixel_RD,
    output logic        dot,
    input  logic [8:0]  set_x,
    input  logic [8:0]  set_y,
    input  logic [8:0]  m_x_1,
    input  logic [8:0]  m_y_1,
    input  logic [8:0]  m_x_2,
    input  logic [8:0]  m_y_2,
    input  logic [8:0]  m_x_3,
    input  logic [8:0]  m_y_3,
    output logic [2:0]  col,
    output logic        gameover,
    output logic [15:0] score
);

    localparam int NT = COLS * ROWS;
    localparam logic [11:0] MAP_W = 12'(TILE * COLS);
    localparam logic [11:0] MAP_H = 12'(TILE * ROWS);

    logic [NT-1:0] eaten_q, eaten_d;
    logic [15:0]   score_q, score_d;
    logic [2:0]    col_q, col_d;

    function automatic logic tile_wall(input logic [5:0] c,
                                       input logic [5:0] r);
        logic [2:0] cm;
        logic [2:0] rm;
        logic       border;
        logic       block;
        cm = 3'(c % 6'd6);
        rm = 3'(r % 6'd6);
        border = (c == 6'd0) || (c == 6'(COLS - 1)) ||
                 (r == 6'd0) || (r == 6'(ROWS - 1));
        block = ((cm == 3'd3) || (cm == 3'd4)) &&
                ((rm == 3'd3) || (rm == 3'd4));
        return border || block;
    endfunction

    function automatic logic tile_path(input logic [5:0] c,
                                       input logic [5:0] r);
        return (c < 6'(COLS)) && (r < 6'(ROWS)) && !tile_wall(c, r);
    endfunction

    // A dot sits where the 2x2 tile block anchored at (c,r) is all path.
    function automatic logic dot_site(input logic [5:0] c,
                                      input logic [5:0] r);
        return tile_path(c, r) && tile_path(c + 6'd1, r) &&
               tile_path(c, r + 6'd1) && tile_path(c + 6'd1, r + 6'd1);
    endfunction

    function automatic logic [1:0] pix_class(input logic [11:0] x,
                                             input logic [11:0] y);
        logic [5:0] c;
        logic [5:0] r;
        logic [1:0] cls;
        c = 6'(x / 12'(TILE));
        r = 6'(y / 12'(TILE));
        if (x >= MAP_W || y >= MAP_H) begin
            cls = 2'b10;
        end else if (tile_wall(c, r)) begin
            cls = 2'b00;
        end else begin
            cls = 2'b01;
        end
        return cls;
    endfunction

    function automatic logic [9:0] tile_idx(input logic [5:0] c,
                                            input logic [5:0] r);
        return 10'(10'(r) * 10'(COLS) + 10'(c));
    endfunction

    function automatic logic near(input logic [8:0] a,
                                  input logic [8:0] b);
        logic signed [9:0] d;
        logic [9:0]        ad;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        ad = d[9] ? 10'(-d) : 10'(d);
        return ad < 10'(COL_DIST);
    endfunction

    // Map queries; offsets are taken at 12 bits so they never wrap.
    logic [11:0] qx, qy, qxr, qyd;
    logic [5:0]  qc, qr;
    logic        q_in;

    always_comb begin
        qx       = {1'b0, query_x};
        qy       = {1'b0, query_y};
        qxr      = qx + 12'(TILE);
        qyd      = qy + 12'(TILE);
        pixel    = pix_class(qx, qy);
        pixel_R  = pix_class(qxr, qy);
        pixel_D  = pix_class(qx, qyd);
        pixel_RD = pix_class(qxr, qyd);
        qc       = 6'(qx / 12'(TILE));
        qr       = 6'(qy / 12'(TILE));
        q_in     = (qx < MAP_W) && (qy < MAP_H);
        dot      = q_in && dot_site(qc, qr) &&
                   !eaten_q[tile_idx(qc, qr)];
    end

    // Eating and collision next-state.
    logic [11:0] sx, sy;
    logic [5:0]  sc, sr;
    logic        s_in, eat;

    always_comb begin
        sx      = {3'b000, set_x};
        sy      = {3'b000, set_y};
        sc      = 6'(sx / 12'(TILE));
        sr      = 6'(sy / 12'(TILE));
        s_in    = (sx < MAP_W) && (sy < MAP_H);
        eat     = !gameover && s_in && dot_site(sc, sr) &&
                  !eaten_q[tile_idx(sc, sr)];
        eaten_d = eaten_q;
        score_d = score_q;
        if (eat) begin
            eaten_d[tile_idx(sc, sr)] = 1'b1;
            score_d = score_q + 16'd1;
        end
        col_d[0] = near(set_x, m_x_1) && near(set_y, m_y_1);
        col_d[1] = near(set_x, m_x_2) && near(set_y, m_y_2);
        col_d[2] = near(set_x, m_x_3) && near(set_y, m_y_3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eaten_q <= '0;
            score_q <= 16'd0;
            col_q   <= 3'b000;
        end else begin
            eaten_q <= eaten_d;
            score_q <= score_d;
            col_q   <= col_d;
        end
    end

    assign col      = col_q;
    assign gameover = |col_q;
    assign score    = score_q;

endmodule

// File: tb/tb_dot_map.sv
// Directed bench for dot_map: map classes, dot eating, score,
// collision flags, gameover freeze and reset behaviour.
module tb_dot_map;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] query_x, query_y;
    logic [1:0]  pixel, pixel_R, pixel_D, pixel_RD;
    logic        dot;
    logic [8:0]  set_x, set_y;
    logic [8:0]  m_x_1, m_y_1, m_x_2, m_y_2, m_x_3, m_y_3;
    logic [2:0]  col;
    logic        gameover;
    logic [15:0] score;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dot_map dut (
        .clk(clk), .reset(reset),
        .query_x(query_x), .query_y(query_y),
        .pixel(pixel), .pixel_R(pixel_R), .pixel_D(pixel_D),
        .pixel_RD(pixel_RD), .dot(dot),
        .set_x(set_x), .set_y(set_y),
        .m_x_1(m_x_1), .m_y_1(m_y_1),
        .m_x_2(m_x_2), .m_y_2(m_y_2),
        .m_x_3(m_x_3), .m_y_3(m_y_3),
        .col(col), .gameover(gameover), .score(score)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic q(input int x, input int y);
        query_x = 11'(x);
        query_y = 11'(y);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        query_x = 0; query_y = 0;
        set_x = 9'd0; set_y = 9'd0;
        m_x_1 = 9'd300; m_y_1 = 9'd300;
        m_x_2 = 9'd300; m_y_2 = 9'd300;
        m_x_3 = 9'd300; m_y_3 = 9'd300;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_score", score, 16'd0);
        chk("rst_col", {13'd0, col}, 16'd0);
        chk("rst_gameover", {15'd0, gameover}, 16'd0);

        q(0, 0);     chk("pix_0_0", {14'd0, pixel}, 16'd0);
        q(12, 12);   chk("pix_12_12", {14'd0, pixel}, 16'd1);
        chk("dot_12_12", {15'd0, dot}, 16'd1);
        q(40, 40);   chk("pix_40_40", {14'd0, pixel}, 16'd0);
        q(400, 0);   chk("pix_400_0", {14'd0, pixel}, 16'd2);
        chk("dot_outside", {15'd0, dot}, 16'd0);
        q(24, 24);
        chk("pix_24", {14'd0, pixel}, 16'd1);
        chk("pixR_24", {14'd0, pixel_R}, 16'd1);
        chk("pixD_24", {14'd0, pixel_D}, 16'd1);
        chk("pixRD_24", {14'd0, pixel_RD}, 16'd0);
        q(340, 0);   chk("pixR_edge", {14'd0, pixel_R}, 16'd2);
        q(2040, 400); chk("pixRD_nowrap", {14'd0, pixel_RD}, 16'd2);
        q(30, 30);   chk("dot_nonsite", {15'd0, dot}, 16'd0);

        // First eat and hold
        set_x = 9'd18; set_y = 9'd18;
        tick();
        chk("eat1_score", score, 16'd1);
        q(12, 12);   chk("eat1_dot", {15'd0, dot}, 16'd0);
        repeat (5) tick();
        chk("hold_score", score, 16'd1);

        // Non-site and outside
        set_x = 9'd30; set_y = 9'd30;
        tick();
        chk("nonsite_score", score, 16'd1);
        set_x = 9'd500; set_y = 9'd500;
        tick();
        chk("outside_score", score, 16'd1);

        // Collision boundary
        set_x = 9'd100; set_y = 9'd100;
        m_x_1 = 9'd112; m_y_1 = 9'd100;
        tick();
        chk("col_dist12", {13'd0, col}, 16'd0);
        m_x_1 = 9'd111;
        tick();
        chk("col_dist11", {13'd0, col}, 16'd1);
        chk("gameover_1", {15'd0, gameover}, 16'd1);
        m_x_1 = 9'd300; m_y_1 = 9'd300;
        m_x_3 = 9'd89;  m_y_3 = 9'd111;
        tick();
        chk("col_m3", {13'd0, col}, 16'd4);

        // Frozen while gameover; collision clears at this edge
        set_x = 9'd66; set_y = 9'd66;
        m_x_3 = 9'd300; m_y_3 = 9'd300;
        tick();
        chk("frozen_score", score, 16'd1);
        chk("col_cleared", {13'd0, col}, 16'd0);
        q(66, 66);   chk("frozen_dot", {15'd0, dot}, 16'd1);
        tick();
        chk("resume_score", score, 16'd2);
        q(66, 66);   chk("resume_dot", {15'd0, dot}, 16'd0);

        // Overlap and eat on the same edge still eats
        set_x = 9'd90; set_y = 9'd18;
        m_x_1 = 9'd90; m_y_1 = 9'd18;
        tick();
        chk("simul_score", score, 16'd3);
        chk("simul_col", {13'd0, col}, 16'd1);

        // Reset with set held on an uneaten dot
        reset = 1'b1;
        set_x = 9'd150; set_y = 9'd150;
        m_x_1 = 9'd300; m_y_1 = 9'd300;
        tick();
        reset = 1'b0;
        chk("rst2_score", score, 16'd0);
        chk("rst2_col", {13'd0, col}, 16'd0);
        chk("rst2_gameover", {15'd0, gameover}, 16'd0);
        q(12, 12);   chk("rst2_dot_a", {15'd0, dot}, 16'd1);
        q(66, 66);   chk("rst2_dot_b", {15'd0, dot}, 16'd1);
        q(90, 18);   chk("rst2_dot_c", {15'd0, dot}, 16'd1);
        q(150, 150); chk("rst2_dot_d", {15'd0, dot}, 16'd1);
        tick();
        chk("post_rst_eat", score, 16'd1);
        chk("post_rst_dot", {15'd0, dot}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
